// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: state encoding and default sizing for the round-robin grant arbiter.
//   arb_state_t   IDLE / GRANT / RELEASE
//   DEF_NREQ      default number of requesters
//   DEF_MAX_HOLD  default maximum grant length in cycles
package rr_arb_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;
    localparam int DEF_NREQ     = 4;
    localparam int DEF_MAX_HOLD = 8;
    localparam int HOLD_W       = 8;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority pick.
//   req    in   request vector
//   last   in   index of the previous owner; scan starts at last+1 and wraps
//   valid  out  at least one request is set
//   idx    out  index of the selected requester (0 when none)
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last,
    output logic                    valid,
    output logic [$clog2(NREQ)-1:0] idx
);
    localparam int IW = $clog2(NREQ);
    always_comb begin
        valid = |req;
        idx   = '0;
        // walk from the farthest offset down so the nearest set bit after last wins
        for (int k = NREQ; k >= 1; k--)
            if (req[(int'(last) + k) % NREQ])
                idx = IW'((int'(last) + k) % NREQ);
    end
endmodule

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: round-robin arbiter with bounded grant length and a mandatory
// release gap between owners.
//   clock    in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   req      in   per-requester request levels
//   done     in   owner release strobe, only looked at while granted
//   gnt      out  registered one-hot grant (zero when nobody owns the resource)
//   gnt_id   out  registered owner index (zero when gnt is zero)
//   busy     out  registered, high while granted or releasing
//   timeout  out  registered one-cycle pulse when the hold limit alone ended a grant
module rr_grant_arbiter
    import rr_arb_pkg::*;
#(
    parameter int NREQ     = DEF_NREQ,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req,
    input  logic                    done,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_id,
    output logic                    busy,
    output logic                    timeout
);
    localparam int IW = $clog2(NREQ);
    arb_state_t        r_state, w_state_nxt;
    logic [NREQ-1:0]   r_gnt, w_gnt_nxt;
    logic [IW-1:0]     r_id, w_id_nxt;
    logic [IW-1:0]     r_last, w_last_nxt;
    logic [HOLD_W-1:0] r_hold, w_hold_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_to, w_to_nxt;
    logic              w_pick_valid;
    logic [IW-1:0]     w_pick_idx;
    logic              w_release;
    logic              w_limit;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req),
        .last  (r_last),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    // owner-driven exit outranks the hold limit, which only decides the timeout pulse
    assign w_release = done || !req[r_id];
    assign w_limit   = r_hold == HOLD_W'(MAX_HOLD - 1);

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = '0;
        w_id_nxt    = '0;
        w_last_nxt  = r_last;
        w_hold_nxt  = r_hold;
        w_busy_nxt  = 1'b0;
        w_to_nxt    = 1'b0;
        unique case (r_state)
            IDLE: if (w_pick_valid) begin
                w_state_nxt = GRANT;
                w_gnt_nxt   = NREQ'(1) << w_pick_idx;
                w_id_nxt    = w_pick_idx;
                w_busy_nxt  = 1'b1;
                w_hold_nxt  = '0;
            end
            GRANT: if (w_release || w_limit) begin
                w_state_nxt = RELEASE;
                w_last_nxt  = r_id;
                w_busy_nxt  = 1'b1;
                w_to_nxt    = !w_release;
                w_hold_nxt  = '0;
            end else begin
                w_gnt_nxt   = r_gnt;
                w_id_nxt    = r_id;
                w_busy_nxt  = 1'b1;
                w_hold_nxt  = (&r_hold) ? r_hold : r_hold + HOLD_W'(1);
            end
            RELEASE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_id    <= '0;
            r_last  <= IW'(NREQ - 1);
            r_hold  <= '0;
            r_busy  <= 1'b0;
            r_to    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_id    <= w_id_nxt;
            r_last  <= w_last_nxt;
            r_hold  <= w_hold_nxt;
            r_busy  <= w_busy_nxt;
            r_to    <= w_to_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign gnt_id  = r_id;
    assign busy    = r_busy;
    assign timeout = r_to;
endmodule

// File: doc/rr_grant_arbiter.md
RR_GRANT_ARBITER -- requirements
Module: rr_grant_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, legal range 2..8.
REQ-002 Parameter MAX_HOLD, default 8: maximum grant length in cycles, legal range 2..255.
REQ-003 clock  input  1  single rising-edge clock for all state.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  NREQ  per-requester request level; bit i set means requester i wants the resource.
REQ-006 done  input  1  current owner's release strobe; qualified only in GRANT.
REQ-007 gnt  output  NREQ  registered one-hot grant, or all-zero when no grant is active.
REQ-008 gnt_id  output  clog2(NREQ)  registered index of the granted requester; 0 when gnt is zero.
REQ-009 busy  output  1  registered; 1 in GRANT and RELEASE.
REQ-010 timeout  output  1  registered one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-011 The FSM SHALL have three states: IDLE, GRANT and RELEASE.
REQ-012 IDLE: if req is nonzero, the FSM SHALL select the first set bit, scanning upward from (last+1) mod NREQ and wrapping, then go to GRANT.
- last = index of the previous owner.
- The same edge SHALL set gnt, gnt_id and busy, so latency from req to gnt is 1 cycle.
REQ-013 IDLE with req zero: the FSM SHALL stay in IDLE with gnt zero.
REQ-014 GRANT: a hold counter SHALL start at 0 on entry and increment every cycle spent in GRANT.
REQ-015 GRANT exit: the FSM SHALL go to RELEASE on the first edge where any of these is true:
- done=1;
- req[owner]=0;
- hold counter = MAX_HOLD-1.
REQ-016 Timeout priority: timeout SHALL pulse only when the hold limit is the sole exit cause; done or a dropped request in the same cycle takes priority and suppresses the pulse.
REQ-017 RELEASE lasts exactly 1 cycle, then the FSM SHALL return to IDLE.
- During RELEASE: gnt zero, gnt_id 0, busy 1.
- On entry to RELEASE: last SHALL be updated to the owner index.
REQ-018 Minimum spacing between two grants SHALL be 2 cycles of zero gnt (RELEASE, then IDLE).
- No back-to-back handover is allowed.
REQ-019 Requests arriving or changing during GRANT or RELEASE SHALL have no effect until IDLE.
REQ-020 Fairness: with all req bits held high, grants SHALL rotate 0,1,...,NREQ-1,0; no requester waits more than NREQ-1 other grants.
REQ-021 done asserted outside GRANT SHALL be ignored.
REQ-022 gnt SHALL never have more than one bit set.
REQ-023 The hold counter SHALL be 8 bits and saturate; it never wraps inside GRANT.

Reset
REQ-024 On reset_n low, asynchronously, the block SHALL force:
- state=IDLE;
- gnt=0, gnt_id=0, busy=0, timeout=0;
- hold counter=0;
- last=NREQ-1, so the first grant scan starts at requester 0.
REQ-025 Reset asserted mid-GRANT SHALL drop the grant immediately, with no RELEASE cycle.
- After reset_n rises, the first edge SHALL behave as IDLE.

Structure
REQ-026 A shared package rr_arb_pkg SHALL hold the state enum (IDLE, GRANT, RELEASE) and the default constants for NREQ and MAX_HOLD.
REQ-027 The rotating priority pick SHALL be one combinational sub-module, rr_pick, with inputs req and last and outputs a valid flag and an index.
REQ-028 rr_grant_arbiter SHALL contain all registers and the FSM.

Verification
REQ-029 Reset check: reset_n=0, then req=4'b1111 -> gnt=0, busy=0; after release, the first grant is gnt=4'b0001 one cycle later.
REQ-030 Rotation: NREQ=4, req=4'b1111 held, done pulsed in each grant's first cycle -> gnt sequence 0001,0010,0100,1000,0001, each grant separated by 2 zero cycles.
REQ-031 Timeout: MAX_HOLD=8, req=4'b0100 held, done=0 -> gnt=0100 for exactly 8 cycles, then timeout=1 for 1 cycle, gnt=0, then gnt=0100 again after IDLE.
REQ-032 Simultaneous exit: in hold cycle 7, assert done=1 together with the limit -> RELEASE entered, timeout stays 0.
REQ-033 Drop and wrap: owner 3 drops req[3] with req=4'b0001 pending -> RELEASE, then gnt=0001 (wrap from 3 to 0).
REQ-034 Mid-grant reset: reset_n pulsed low during GRANT of requester 2 -> gnt=0 immediately; with req=4'b0100 after release, the next grant is 0100 with last=NREQ-1 priority.
